// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg
// Shared definitions for the multiplier command sequencer and the multiplier
// datapath: op-code constants, FSM state encoding and a helper that maps a
// command index onto the op-code it issues.
package mul_seq_pkg;

    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_LOAD_A = 2'b01;
    localparam logic [1:0] OP_LOAD_B = 2'b10;
    localparam logic [1:0] OP_STEP   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Command index 0 clears, 1/2 load the operands, everything after is a STEP.
    function automatic logic [1:0] op_for_idx(input int unsigned idx);
        case (idx)
            0:       return OP_CLEAR;
            1:       return OP_LOAD_A;
            2:       return OP_LOAD_B;
            default: return OP_STEP;
        endcase
    endfunction

endpackage

// File: rtl/mul_seq_watchdog.sv
// mul_seq_watchdog
// Counts cycles spent waiting on one multiplier command.
// Ports:
//   clk, reset  clock / synchronous active-high reset
//   load        restart the count (asserted while a command is being issued)
//   enable      count this cycle (asserted while waiting for mul_done)
//   expired     combinational: this is the TIMEOUT-th waiting cycle
module mul_seq_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of waiting cycles already completed, so the
    // TIMEOUT-th waiting cycle is the one that sees cnt == TIMEOUT-1.
    assign expired = enable && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mul_cmd_sequencer.sv
// mul_cmd_sequencer
// Feeds the 8x8 shift-add multiplier its full command sequence for one
// operand pair (CLEAR, LOAD_A, LOAD_B, N_STEPS x STEP) and returns the
// 16-bit product over a valid/ready response interface.
// Ports:
//   clk, reset                 clock / synchronous active-high reset
//   req_valid/req_ready        operand request handshake, req_a/req_b operands
//   resp_valid/resp_ready      product handshake, resp_prod/resp_err payload
//   mul_s/mul_op/mul_in        command start pulse, op-code, operand
//   mul_done/mul_out           multiplier completion and accumulator
// Build option: MUL_SEQ_TIMEOUT_EN adds a per-command watchdog; a command that
// sees no mul_done within TIMEOUT waiting cycles aborts with resp_err=1 and
// resp_prod=0. Without it resp_err is always 0 and WAIT never gives up.
module mul_cmd_sequencer
    import mul_seq_pkg::*;
#(
    parameter int N_STEPS = 8,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_prod,
    output logic        resp_err,
    output logic        mul_s,
    output logic [1:0]  mul_op,
    output logic [7:0]  mul_in,
    input  logic        mul_done,
    input  logic [15:0] mul_out
);
    localparam int CMD_W = $clog2(N_STEPS + 3);
    localparam logic [CMD_W-1:0] LAST_IDX = CMD_W'(N_STEPS + 2);

    state_t           state;
    logic [CMD_W-1:0] cmd_idx;
    logic [7:0]       a_reg;
    logic [7:0]       b_reg;
    logic             wait_first;
    logic             wd_expired;

    // Command that follows the current one; only meaningful below LAST_IDX.
    logic [CMD_W-1:0] nxt_idx;
    logic [1:0]       nxt_op;
    logic [7:0]       nxt_in;

    always_comb begin
        nxt_idx = cmd_idx + 1'b1;
        nxt_op  = op_for_idx(int'(nxt_idx));
        nxt_in  = 8'd0;
        if (nxt_op == OP_LOAD_A) nxt_in = a_reg;
        if (nxt_op == OP_LOAD_B) nxt_in = b_reg;
    end

`ifdef MUL_SEQ_TIMEOUT_EN
    mul_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .load    (state == S_ISSUE),
        .enable  (state == S_WAIT),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cmd_idx    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            wait_first <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_prod  <= '0;
            resp_err   <= 1'b0;
            mul_s      <= 1'b0;
            mul_op     <= OP_CLEAR;
            mul_in     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        a_reg     <= req_a;
                        b_reg     <= req_b;
                        cmd_idx   <= '0;
                        req_ready <= 1'b0;
                        // Outputs are registered, so the first command is
                        // launched on the transition into ISSUE.
                        mul_s     <= 1'b1;
                        mul_op    <= OP_CLEAR;
                        mul_in    <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mul_s      <= 1'b0;
                    wait_first <= 1'b1;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    wait_first <= 1'b0;
                    // A done still high from the previous command is
                    // visible in the first WAIT cycle, so it is skipped.
                    if (!wait_first && mul_done) begin
                        if (cmd_idx == LAST_IDX) begin
                            resp_prod  <= mul_out;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            cmd_idx <= nxt_idx;
                            mul_s   <= 1'b1;
                            mul_op  <= nxt_op;
                            mul_in  <= nxt_in;
                            state   <= S_ISSUE;
                        end
                    end else if (wd_expired) begin
                        resp_prod  <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_cmd_sequencer.sv
// Self-checking bench for mul_cmd_sequencer with a behavioural shift-add
// multiplier. Expected products go into a scoreboard queue when a request is
// driven and are popped when the response appears.
module tb_mul_cmd_sequencer;
    import mul_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_a = '0;
    logic [7:0]  req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_prod;
    logic        resp_err;
    logic        mul_s;
    logic [1:0]  mul_op;
    logic [7:0]  mul_in;
    logic        mul_done;
    logic [15:0] mul_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_cmd_sequencer #(.N_STEPS(8), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_prod  (resp_prod),
        .resp_err   (resp_err),
        .mul_s      (mul_s),
        .mul_op     (mul_op),
        .mul_in     (mul_in),
        .mul_done   (mul_done),
        .mul_out    (mul_out)
    );

    // ---------------- behavioural multiplier ----------------
    // done_mode: 0 = done one cycle after the start pulse ends,
    //            1 = done stuck high, 2 = never done for LOAD_B.
    int          done_mode = 0;
    logic        s_d = 1'b0;
    logic [1:0]  op_d = 2'b00;
    logic        done_r = 1'b0;
    logic [15:0] acc = '0;
    logic [7:0]  ma = '0;
    logic [7:0]  mb = '0;
    int          k = 0;

    assign mul_done = done_r;
    assign mul_out  = acc;

    always @(posedge clk) begin
        s_d  <= mul_s;
        op_d <= mul_op;
        case (done_mode)
            1:       done_r <= 1'b1;
            2:       done_r <= s_d && (op_d != OP_LOAD_B);
            default: done_r <= s_d;
        endcase
        if (mul_s) begin
            case (mul_op)
                OP_CLEAR:  begin acc <= '0; ma <= '0; mb <= '0; k <= 0; end
                OP_LOAD_A: ma <= mul_in;
                OP_LOAD_B: mb <= mul_in;
                default: begin
                    if (mb[0]) acc <= acc + (16'(ma) << k);
                    mb <= mb >> 1;
                    k  <= k + 1;
                end
            endcase
        end
    end

    // ---------------- command monitor ----------------
    logic [1:0] log_op[$];
    logic [7:0] log_in[$];
    always @(posedge clk) begin
        if (mul_s) begin
            log_op.push_back(mul_op);
            log_in.push_back(mul_in);
        end
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [15:0] exp_p;

    // Drive one request; returns at the negedge right after the accept edge.
    task automatic issue_req(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL req_accept_wait: req_ready=%0b required 1", req_ready);
        end
        req_valid = 1'b1; req_a = a; req_b = b;
        exp_q.push_back(exp);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Counts cycles until resp_valid; lat includes the accept cycle.
    task automatic wait_resp(output int lat, output bit to);
        int n = 0;
        while (!resp_valid && n < 300) begin @(negedge clk); n++; end
        lat = n + 1;
        to  = !resp_valid;
    endtask

    task automatic ack_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, mul_s} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: rdy/vld/err/s=%b required 1000",
                     {req_ready, resp_valid, resp_err, mul_s});
        end
        checks++;
        if ({resp_prod, mul_op, mul_in} !== 26'd0) begin
            errors++;
            $display("FAIL reset_data: prod=%h op=%b in=%h required 0", resp_prod, mul_op, mul_in);
        end
        reset = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [7:0] a, input logic [7:0] b);
        int lat; bit to;
        log_op.delete(); log_in.delete();
        issue_req(a, b, 16'(a) * 16'(b));
        wait_resp(lat, to);
        exp_p = exp_q.pop_front();
        checks++;
        if (to || lat != 34) begin
            errors++;
            $display("FAIL %s_latency: got %0d timeout=%0b required 34", name, lat, to);
        end
        checks++;
        if (resp_prod !== exp_p || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_prod: got %h err=%b required %h err=0", name, resp_prod, resp_err, exp_p);
        end
        checks++;
        if (log_op.size() != 11) begin
            errors++;
            $display("FAIL %s_cmd_count: got %0d required 11", name, log_op.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                logic [1:0] eo;
                logic [7:0] ei;
                eo = (i == 0) ? OP_CLEAR : (i == 1) ? OP_LOAD_A : (i == 2) ? OP_LOAD_B : OP_STEP;
                ei = (i == 1) ? a : (i == 2) ? b : 8'd0;
                checks++;
                if (log_op[i] !== eo || log_in[i] !== ei) begin
                    errors++;
                    $display("FAIL %s_cmd%0d: got op=%b in=%h required op=%b in=%h",
                             name, i, log_op[i], log_in[i], eo, ei);
                end
            end
        end
        ack_resp();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: vld=%b rdy=%b required 0/1", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_basic();
        run_one("basic_13x11", 8'd13, 8'd11);
    endtask

    task automatic test_corners();
        run_one("max_255x255", 8'd255, 8'd255);
        run_one("zero_0x200", 8'd0, 8'd200);
    endtask

    task automatic test_back_to_back();
        int lat; bit to;
        logic [15:0] held;
        issue_req(8'd7, 8'd9, 16'd63);
        wait_resp(lat, to);
        exp_p = exp_q.pop_front();
        checks++;
        if (to || resp_prod !== exp_p) begin
            errors++;
            $display("FAIL b2b_first: got %h timeout=%0b required %h", resp_prod, to, exp_p);
        end
        held = resp_prod;
        // Offer the next request while the response is stalled.
        req_valid = 1'b1; req_a = 8'd5; req_b = 8'd6;
        exp_q.push_back(16'd30);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_prod !== held || req_ready !== 1'b0 || mul_s !== 1'b0) begin
                errors++;
                $display("FAIL b2b_stall%0d: vld=%b prod=%h rdy=%b s=%b required 1/%h/0/0",
                         i, resp_valid, resp_prod, req_ready, mul_s, held);
            end
        end
        log_op.delete(); log_in.delete();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mul_s !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: vld=%b rdy=%b s=%b required 0/1/0", resp_valid, req_ready, mul_s);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || mul_s !== 1'b1 || mul_op !== OP_CLEAR) begin
            errors++;
            $display("FAIL b2b_accept: rdy=%b s=%b op=%b required 0/1/00", req_ready, mul_s, mul_op);
        end
        wait_resp(lat, to);
        exp_p = exp_q.pop_front();
        checks++;
        if (to || lat != 34 || resp_prod !== exp_p) begin
            errors++;
            $display("FAIL b2b_second: got %h lat=%0d required %h lat=34", resp_prod, lat, exp_p);
        end
        ack_resp();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        log_op.delete(); log_in.delete();
        issue_req(8'd20, 8'd21, 16'd420);
        while (log_op.size() < 5 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (log_op.size() < 5 || mul_s !== 1'b0 || mul_op !== OP_STEP) begin
            errors++;
            $display("FAIL rstmid_reach: cmds=%0d s=%b op=%b required 5/0/11", log_op.size(), mul_s, mul_op);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_back());
        checks++;
        if (mul_s !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: s=%b rdy=%b vld=%b required 0/1/0", mul_s, req_ready, resp_valid);
        end
        run_one("after_rst_3x4", 8'd3, 8'd4);
    endtask

    task automatic test_stale_done();
        done_mode = 1;
        run_one("stale_9x10", 8'd9, 8'd10);
        done_mode = 0;
    endtask

    task automatic test_timeout();
        int lat; bit to;
        done_mode = 2;
`ifdef MUL_SEQ_TIMEOUT_EN
        issue_req(8'd6, 8'd7, 16'd0);
        wait_resp(lat, to);
        exp_p = exp_q.pop_front();
        // CLEAR and LOAD_A take 3 cycles each, LOAD_B ISSUE 1 + 16 WAIT.
        checks++;
        if (to || lat != 24) begin
            errors++;
            $display("FAIL timeout_latency: got %0d timeout=%0b required 24", lat, to);
        end
        checks++;
        if (resp_err !== 1'b1 || resp_prod !== exp_p) begin
            errors++;
            $display("FAIL timeout_resp: err=%b prod=%h required 1/%h", resp_err, resp_prod, exp_p);
        end
        ack_resp();
        checks++;
        if (resp_err !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_clear: err=%b rdy=%b required 0/1", resp_err, req_ready);
        end
        done_mode = 0;
`else
        issue_req(8'd6, 8'd7, 16'd42);
        repeat (60) @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || mul_s !== 1'b0 || mul_op !== OP_LOAD_B) begin
            errors++;
            $display("FAIL hang_wait: vld=%b err=%b s=%b op=%b required 0/0/0/10",
                     resp_valid, resp_err, mul_s, mul_op);
        end
        void'(exp_q.pop_back());
        done_mode = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL hang_recover: rdy=%b vld=%b required 1/0", req_ready, resp_valid);
        end
`endif
        run_one("post_timeout_2x3", 8'd2, 8'd3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_reset_mid();
        test_stale_done();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_cmd_sequencer.md
Name: mul_cmd_sequencer

Overview:
Upstream command sequencer for the 8x8 shift-add multiplier datapath. The multiplier takes single-command ops on mul_op/mul_in, qualified by a start pulse (mul_s), and returns mul_done.
- Accepts an operand pair over a valid/ready request interface.
- Drives the full command sequence: CLEAR, LOAD_A, LOAD_B, then N_STEPS x STEP.
- Captures the 16-bit product and presents it on a valid/ready response interface.
- Sits between the operand source and the multiplier; owns all multiplier control except the multiplier's own reset.

Parameters:
N_STEPS, 8, number of STEP commands issued per multiply (equals operand width).
TIMEOUT, 16, max cycles spent in WAIT for one command (used only with MUL_SEQ_TIMEOUT_EN).

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  operand pair available
req_ready  out  1  sequencer can accept operands
req_a  in  8  multiplicand
req_b  in  8  multiplier
resp_valid  out  1  product available
resp_ready  in  1  consumer takes product
resp_prod  out  16  product
resp_err  out  1  command timed out (0 when feature compiled out)
mul_s  out  1  start pulse to multiplier
mul_op  out  2  00 CLEAR, 01 LOAD_A, 10 LOAD_B, 11 STEP
mul_in  out  8  operand for LOAD_A/LOAD_B, 0 otherwise
mul_done  in  1  multiplier finished current command
mul_out  in  16  multiplier accumulator

Behaviour:
- Reset: synchronous, active-high, clock clk.
  - State IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_prod=0.
  - mul_s=0; mul_op=00; mul_in=0.
  - Command counter and operand registers cleared.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req_a/req_b, set cmd_idx=0, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mul_s=1.
  - mul_op/mul_in from cmd_idx: 0 -> CLEAR/0; 1 -> LOAD_A/a; 2 -> LOAD_B/b; 3..N_STEPS+2 -> STEP/0.
  - Next state WAIT.
- WAIT:
  - mul_s=0; mul_op/mul_in held.
  - mul_done is ignored in the first WAIT cycle, so a stale done from the previous command is never taken.
  - mul_done=1 on a later cycle:
    - If cmd_idx==N_STEPS+2: resp_prod<=mul_out, go to RESP.
    - Otherwise: cmd_idx+=1, go to ISSUE.
- RESP:
  - resp_valid=1; resp_prod and resp_err stable.
  - On resp_ready: resp_valid=0, req_ready=1, go to IDLE.
  - Next request is not accepted in the same cycle as resp_ready.
- req_ready=0 in ISSUE, WAIT and RESP; req_valid is ignored there.
- Fixed command count: operands of 0 still issue all N_STEPS+3 commands. No early exit.
- Latency (multiplier raises done 1 cycle after mul_s):
  - 1 accept cycle + (N_STEPS+3) x 3 cycles per command + response.
  - For N_STEPS=8: resp_valid rises 34 cycles after the accept edge.
- cmd_idx width is clog2(N_STEPS+3); no wrap is possible.
- Reset mid-operation:
  - Returns to IDLE within 1 cycle; mul_s deasserted; pending result dropped.
  - The multiplier is not re-cleared until the next request's CLEAR.
- resp_ready held high in RESP: a single-cycle resp_valid pulse is allowed.

Optional Feature:
MUL_SEQ_TIMEOUT_EN
- Defined:
  - A watchdog counts WAIT cycles, reloaded on each ISSUE.
  - Reaching TIMEOUT without mul_done aborts the sequence: go to RESP with resp_err=1, resp_prod=0.
  - resp_err clears on leaving RESP.
- Not defined: no counter; WAIT waits indefinitely; resp_err tied 0.

Decomposition:
- Shared package mul_seq_pkg:
  - Op-code constants OP_CLEAR/OP_LOAD_A/OP_LOAD_B/OP_STEP. The multiplier uses the same constants.
  - State encoding constants.
- Optional sub-module mul_seq_watchdog (load, enable, expired), instantiated only under MUL_SEQ_TIMEOUT_EN.
- The FSM and command counter stay in the top.

Test Plan (bench uses a behavioural multiplier model that raises done 1 cycle after mul_s and computes a*b):
- a=13, b=11 -> command order CLEAR, LOAD_A(13), LOAD_B(11), 8xSTEP; resp_prod=0x008F, resp_err=0; resp_valid 34 cycles after accept.
- a=255, b=255 -> resp_prod=0xFE01. Then a=0, b=200 -> resp_prod=0x0000, still 11 commands issued.
- Backpressure:
  - Hold resp_ready=0 for 10 cycles in RESP -> resp_valid and resp_prod stable, req_ready=0.
  - Release -> IDLE next cycle; second request with req_valid held high is accepted the cycle after.
- Assert reset during WAIT of the 5th command -> next cycle IDLE, mul_s=0, req_ready=1. New request 3x4 -> resp_prod=0x000C.
- Stale done: model holds done high continuously -> each command still spends at least 2 WAIT cycles; sequence and product correct.
- MUL_SEQ_TIMEOUT_EN, TIMEOUT=16: model never raises done on the LOAD_B command -> RESP after 16 WAIT cycles, resp_err=1, resp_prod=0. Without the macro, the sequencer stays in WAIT.
